// File: rtl/gru_pkg.sv
// Shared types and default widths for the GRU cell and its channel arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gru_pkg;

  localparam int DATA_WIDTH_DEF     = 32;
  localparam int GRU_UNITS_DEF      = 3;
  localparam int INPUT_FEATURES_DEF = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } arb_state_e;

endpackage

// File: rtl/gru_cell_arbiter_if.sv
// Bundle of request, cell and result signals around the GRU cell arbiter.
// Latency: n/a (wiring only).
// Backpressure: o_res_valid/i_res_ready on the result side, o_req_ready pulses on requests.
interface gru_cell_arbiter_if #(
  parameter int DATA_WIDTH     = gru_pkg::DATA_WIDTH_DEF,
  parameter int GRU_UNITS      = gru_pkg::GRU_UNITS_DEF,
  parameter int INPUT_FEATURES = gru_pkg::INPUT_FEATURES_DEF,
  parameter int NUM_CH         = 4
);
  localparam int HW = GRU_UNITS * DATA_WIDTH;
  localparam int XW = INPUT_FEATURES * DATA_WIDTH;
  localparam int CW = $clog2(NUM_CH);

  logic [NUM_CH-1:0]    i_req_valid;
  logic [NUM_CH-1:0]    i_req_first;
  logic [NUM_CH*XW-1:0] i_req_x;
  logic [NUM_CH-1:0]    o_req_ready;
  logic                 o_cell_start;
  logic [XW-1:0]        o_cell_x;
  logic [HW-1:0]        o_cell_h;
  logic                 i_cell_done;
  logic [HW-1:0]        i_cell_h;
  logic                 o_res_valid;
  logic                 i_res_ready;
  logic [CW-1:0]        o_res_ch;
  logic                 o_res_last;
  logic [HW-1:0]        o_res_h;
  logic                 o_err_timeout;

  // Arbiter side
  modport master (
    input  i_req_valid, i_req_first, i_req_x, i_cell_done, i_cell_h, i_res_ready,
    output o_req_ready, o_cell_start, o_cell_x, o_cell_h,
           o_res_valid, o_res_ch, o_res_last, o_res_h, o_err_timeout
  );

  // Framers, cell and result consumer side
  modport slave (
    output i_req_valid, i_req_first, i_req_x, i_cell_done, i_cell_h, i_res_ready,
    input  o_req_ready, o_cell_start, o_cell_x, o_cell_h,
           o_res_valid, o_res_ch, o_res_last, o_res_h, o_err_timeout
  );

endinterface

// File: rtl/gru_cell_arbiter_rr.sv
// Round-robin picker: first requester after the previous winner, wrapping around.
// Latency: purely combinational.
// Backpressure: none; caller decides when the grant is consumed.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] last,
  output logic [N-1:0]  grant_onehot,
  output logic [CW-1:0] grant_idx
);

  logic [CW-1:0] cand;
  logic          found;

  // Walk last+1 .. last+N (mod N) and keep the first requester seen
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    found        = 1'b0;
    cand         = '0;
    for (int k = 1; k <= N; k++) begin
      cand = CW'((int'(last) + k) % N);
      if (!found && req[cand]) begin
        found              = 1'b1;
        grant_onehot[cand] = 1'b1;
        grant_idx          = cand;
      end
    end
  end

endmodule

// File: rtl/gru_cell_arbiter.sv
// Shares one GRU cell between NUM_CH channels, keeping a hidden state per channel.
// Latency: accept at T, start at T+1, result valid at T+2+L for cell latency L.
// Backpressure: result held until i_res_ready; no new request accepted meanwhile.
module gru_cell_arbiter
  import gru_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int GRU_UNITS      = GRU_UNITS_DEF,
  parameter int INPUT_FEATURES = INPUT_FEATURES_DEF,
  parameter int NUM_CH         = 4,
  parameter int SEQ_LENGTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                clk,
  input logic                rstn,
  gru_cell_arbiter_if.master bus
);

  localparam int HW = GRU_UNITS * DATA_WIDTH;
  localparam int XW = INPUT_FEATURES * DATA_WIDTH;
  localparam int CW = $clog2(NUM_CH);
  localparam int SW = (SEQ_LENGTH > 1) ? $clog2(SEQ_LENGTH) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] last_q, last_d;
  logic [CW-1:0] cur_ch_q, cur_ch_d;
  logic [SW-1:0] cur_step_q, cur_step_d;
  logic [XW-1:0] x_q, x_d;
  logic [HW-1:0] cell_h_q, cell_h_d;
  logic [HW-1:0] h_q [NUM_CH];
  logic [HW-1:0] h_d [NUM_CH];
  logic [SW-1:0] step_q [NUM_CH];
  logic [SW-1:0] step_d [NUM_CH];
  logic [TW-1:0] wdog_q, wdog_d;
  logic [CW-1:0] res_ch_q, res_ch_d;
  logic          res_last_q, res_last_d;
  logic [HW-1:0] res_h_q, res_h_d;
  logic          err_q, err_d;

  logic [NUM_CH-1:0] grant_oh;
  logic [CW-1:0]     grant_idx;
  logic              fresh;

  rr_arbiter #(.N(NUM_CH), .CW(CW)) u_rr (
    .req          (bus.i_req_valid),
    .last         (last_q),
    .grant_onehot (grant_oh),
    .grant_idx    (grant_idx)
  );

  // State, per-channel history and result registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      last_q     <= CW'(NUM_CH - 1);
      cur_ch_q   <= '0;
      cur_step_q <= '0;
      x_q        <= '0;
      cell_h_q   <= '0;
      wdog_q     <= '0;
      res_ch_q   <= '0;
      res_last_q <= 1'b0;
      res_h_q    <= '0;
      err_q      <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        h_q[c]    <= '0;
        step_q[c] <= '0;
      end
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cur_ch_q   <= cur_ch_d;
      cur_step_q <= cur_step_d;
      x_q        <= x_d;
      cell_h_q   <= cell_h_d;
      wdog_q     <= wdog_d;
      res_ch_q   <= res_ch_d;
      res_last_q <= res_last_d;
      res_h_q    <= res_h_d;
      err_q      <= err_d;
      h_q        <= h_d;
      step_q     <= step_d;
    end
  end

  // Next-state: grant, issue, wait for done or watchdog, hold result
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cur_ch_d   = cur_ch_q;
    cur_step_d = cur_step_q;
    x_d        = x_q;
    cell_h_d   = cell_h_q;
    wdog_d     = wdog_q;
    res_ch_d   = res_ch_q;
    res_last_d = res_last_q;
    res_h_d    = res_h_q;
    err_d      = err_q;
    h_d        = h_q;
    step_d     = step_q;
    fresh      = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.i_req_valid) begin
          // A new sequence (explicit or by step wrap) starts from a zero hidden state
          fresh      = bus.i_req_first[grant_idx] || (step_q[grant_idx] == '0);
          x_d        = bus.i_req_x[grant_idx*XW +: XW];
          cell_h_d   = fresh ? '0 : h_q[grant_idx];
          cur_step_d = fresh ? '0 : step_q[grant_idx];
          cur_ch_d   = grant_idx;
          last_d     = grant_idx;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.i_cell_done) begin
          h_d[cur_ch_q]    = bus.i_cell_h;
          step_d[cur_ch_q] = (cur_step_q == SW'(SEQ_LENGTH - 1)) ? '0 : cur_step_q + 1'b1;
          res_ch_d         = cur_ch_q;
          res_last_d       = (cur_step_q == SW'(SEQ_LENGTH - 1));
          res_h_d          = bus.i_cell_h;
          state_d          = RESULT;
        end else if (wdog_q == TW'(TIMEOUT_CYCLES - 1)) begin
          // Request is dropped; channel history stays as it was
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      RESULT: begin
        if (bus.i_res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is gated by reset so every output reads zero while rstn is low
  assign bus.o_req_ready   = (rstn && state_q == IDLE) ? grant_oh : '0;
  assign bus.o_cell_start  = (state_q == ISSUE);
  assign bus.o_cell_x      = x_q;
  assign bus.o_cell_h      = cell_h_q;
  assign bus.o_res_valid   = (state_q == RESULT);
  assign bus.o_res_ch      = res_ch_q;
  assign bus.o_res_last    = res_last_q;
  assign bus.o_res_h       = res_h_q;
  assign bus.o_err_timeout = err_q;

endmodule

// File: doc/gru_cell_arbiter.md
# gru_cell_arbiter

Time-multiplexes a single `GRU_Cell` datapath between `NUM_CH` independent equalizer channels.
- Each channel presents one input vector per time step.
- The block grants one channel at a time (round-robin), sequences the cell's start/done handshake and keeps a private hidden-state register per channel.
- It returns each new hidden vector on a back-pressured result port.
- It sits between the per-channel sample framers and the one `GRU_Cell` instance, replacing the single-sequence processing sub-FSM used when only one channel exists.

## Interface
Parameters:
- `DATA_WIDTH`, 32, word width (fixed-point, opaque to this block)
- `GRU_UNITS`, 3, hidden vector length
- `INPUT_FEATURES`, 3, input vector length
- `NUM_CH`, 4, requesting channels (2..8)
- `SEQ_LENGTH`, 4, time steps per sequence
- `TIMEOUT_CYCLES`, 1024, watchdog limit for `i_cell_done`

Ports (HW = `GRU_UNITS*DATA_WIDTH`, XW = `INPUT_FEATURES*DATA_WIDTH`, CW = `$clog2(NUM_CH)`):
- `clk`  in  1  clock
- `rstn`  in  1  asynchronous, active-low reset
- `i_req_valid`  in  NUM_CH  channel has a step pending
- `i_req_first`  in  NUM_CH  pending step is step 0 of a new sequence
- `i_req_x`  in  NUM_CH*XW  per-channel input vectors, channel c at `[c*XW +: XW]`
- `o_req_ready`  out  NUM_CH  one-hot, 1-cycle acceptance pulse
- `o_cell_start`  out  1  1-cycle start pulse to cell
- `o_cell_x`  out  XW  input vector to cell
- `o_cell_h`  out  HW  previous hidden state to cell
- `i_cell_done`  in  1  cell done pulse
- `i_cell_h`  in  HW  new hidden state from cell
- `o_res_valid`  out  1  result available
- `i_res_ready`  in  1  result consumer ready
- `o_res_ch`  out  CW  channel of result
- `o_res_last`  out  1  result is step `SEQ_LENGTH-1`
- `o_res_h`  out  HW  new hidden vector
- `o_err_timeout`  out  1  sticky watchdog flag

## Operation
FSM states: `IDLE`, `ISSUE`, `WAIT`, `RESULT`.

**IDLE**
- If any `i_req_valid` bit is set, grant channel g using round-robin priority starting at `last_grant+1` (mod `NUM_CH`).
- Assert `o_req_ready[g]` this cycle.
- Latch `i_req_x[g]` into `x_reg`, set `cur_ch<=g`, set `last_grant<=g`, go to `ISSUE`.

**Step counter and hidden state**
- If `i_req_first[g]=1`, or `step[g]==0`, the cell uses h = 0 and `step[g]` is treated as 0.
- Otherwise the cell uses `h_reg[g]`.

**ISSUE**
- `o_cell_start=1` for exactly this cycle.
- Clear the watchdog, go to `WAIT`.

**WAIT**
- Count cycles.
- On `i_cell_done`:
  - `h_reg[cur_ch]<=i_cell_h`.
  - Load the result registers: `o_res_ch=cur_ch`; `o_res_last=(step==SEQ_LENGTH-1)`.
  - `step[cur_ch]<=` step+1, wrapping to 0 after `SEQ_LENGTH-1`.
  - Go to `RESULT`.
- If the watchdog reaches `TIMEOUT_CYCLES` first:
  - Set `o_err_timeout`.
  - Leave `h_reg` and `step` unchanged.
  - Go to `IDLE`. The request is consumed and no result is produced.

**RESULT**
- Hold `o_res_valid=1` with stable payload until `i_res_ready=1`, then go to `IDLE`.

**Cell input stability**
- `o_cell_x` and `o_cell_h` are driven from registers.
- They are stable from `ISSUE` through the end of `WAIT`.

**Boundary conditions**
- `i_cell_done` outside `WAIT` is ignored.
- Requests arriving during `ISSUE`/`WAIT`/`RESULT` wait. `o_req_ready` stays 0 outside `IDLE`.
- A single valid channel is re-granted every transaction; round-robin must not starve it.
- With all channels valid, grants rotate 0,1,2,…,NUM_CH-1,0.
- `i_req_first` on a channel mid-sequence discards that channel's history (h = 0, step 0). Other channels are unaffected.
- `o_err_timeout` clears only on reset.

## Timing
Reset values:
- FSM `IDLE`.
- All outputs 0.
- `last_grant=NUM_CH-1`, so channel 0 wins first.
- All `h_reg` and `step` cleared to 0.

Cycle-level behaviour, with acceptance at cycle T and cell latency L (done at T+1+L):
- `o_cell_start` at T+1.
- `o_res_valid` rises at T+2+L.
- Minimum step period is L+3 cycles with `i_res_ready` tied high.

Reset mid-operation:
- Immediately drops `o_cell_start` and `o_res_valid`.
- The cell must be reset by the same `rstn`.

## Structure
Shared package `gru_pkg` holds:
- the FSM state encoding;
- the `DATA_WIDTH`, `GRU_UNITS` and `INPUT_FEATURES` defaults shared with `GRU_Cell` and the wrapper.

Sub-module:
- `rr_arbiter` (parameter N): inputs `req[N]` and `last[CW]`; outputs `grant_onehot` and `grant_idx`; purely combinational.
- The FSM, per-channel `h_reg`/`step` arrays and watchdog stay in this block.

## Test plan
Use a behavioural cell model with L=10, `i_cell_h = i_cell_h_prev + x` elementwise.

- **Single channel:** ch1 valid with first=1 for 4 steps, x=1 → results on ch1 h=1,2,3,4; `o_res_last` only on the 4th; step period 13 cycles.
- **Rotation:** all 4 channels valid continuously → grant order 0,1,2,3,0,1; each channel's h independent.
- **Restart:** `i_req_first` on ch2 at step 2 → ch2 result h=x (history discarded); ch0 h unaffected.
- **Backpressure:** `i_res_ready` low 20 cycles → `o_res_valid` and payload stable, no new `o_req_ready`, no `o_cell_start`.
- **Watchdog:** cell never asserts done → `o_err_timeout`=1 after 1024 `WAIT` cycles; FSM returns to `IDLE`; next request is served normally with `h_reg` unchanged.
- **Async reset mid-WAIT:** `rstn`=0 → all outputs 0 immediately; after release, first grant goes to ch0 and uses h=0.
